// File: rtl/oled_spi_tx_pkg.sv
// Shared types and constants for the OLED SPI byte transmitter.
package oled_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } spi_state_t;

   localparam int SPI_BITS = 8;

   localparam logic OLED_CMD  = 1'b0;
   localparam logic OLED_DATA = 1'b1;

   localparam int DEFAULT_CLK_DIV    = 5;
   localparam int DEFAULT_FIFO_DEPTH = 4;

   // One queued transfer: the D/C# level travels with its byte.
   typedef struct packed {
      logic                dc_n;
      logic [SPI_BITS-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/oled_spi_tx_if.sv
// Producer-side byte handshake into the OLED SPI transmitter.
interface oled_spi_tx_if;
   import oled_pkg::*;

   logic [SPI_BITS-1:0] tx_data;
   logic                tx_dc_n;
   logic                tx_valid;
   logic                tx_ready;

   modport master (
      output tx_data,
      output tx_dc_n,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_dc_n,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/oled_spi_tx_fifo.sv
// Small synchronous FIFO holding {dc_n, data} entries ahead of the serializer.
module oled_byte_fifo
   import oled_pkg::*;
#(
   parameter int WIDTH = $bits(fifo_entry_t),
   parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO refuses the push even when a pop frees a slot this cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/oled_spi_tx.sv
// SPI byte transmitter for the OLED panel: queues {dc_n, byte} entries and
// shifts each byte out MSB-first with SCLK idling high.
module oled_spi_tx
   import oled_pkg::*;
#(
   parameter int CLK_DIV    = DEFAULT_CLK_DIV,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic         clock,
   input  logic         reset,
   oled_spi_tx_if.slave tx,
   output logic         busy,
   output logic         byte_done,
   output logic         oled_spi_clk,
   output logic         oled_spi_data,
   output logic         oled_dc_n
);

   localparam int HW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(SPI_BITS);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(SPI_BITS - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

   spi_state_t          state_q;
   spi_state_t          state_d;
   logic [HW-1:0]       hcnt_q;
   logic [HW-1:0]       hcnt_d;
   logic [BW-1:0]       bit_q;
   logic [BW-1:0]       bit_d;
   logic [SPI_BITS-1:0] shreg_q;
   logic [SPI_BITS-1:0] shreg_d;
   logic                sclk_d;
   logic                dcn_d;
   logic                done_d;
   logic                busy_d;
   logic                ready_d;

   fifo_entry_t   head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_next;
   logic          push_eff;
   logic          do_pop;

   assign push_eff = tx.tx_valid && tx.tx_ready && !fifo_full;

   oled_byte_fifo #(
      .WIDTH($bits(fifo_entry_t)),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock(clock),
      .reset(reset),
      .push (push_eff),
      .pop  (do_pop),
      .wdata({tx.tx_dc_n, tx.tx_data}),
      .rdata(head),
      .full (fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
   );

   // Occupancy after this edge, so tx_ready and busy are exact when registered.
   assign count_next = fifo_count + CW'(push_eff) - CW'(do_pop);
   assign ready_d    = (count_next != FULL_CNT);
   assign busy_d     = (state_d != IDLE) || (count_next != '0);

   // The MSB of the shift register is the MOSI pin, so it is registered too.
   assign oled_spi_data = shreg_q[SPI_BITS-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      sclk_d  = oled_spi_clk;
      dcn_d   = oled_dc_n;
      done_d  = 1'b0;
      do_pop  = 1'b0;

      case (state_q)
         IDLE: begin
            sclk_d  = 1'b1;
            shreg_d = '0;
            hcnt_d  = '0;
            bit_d   = '0;
            if (!fifo_empty) begin
               state_d = LOAD;
               dcn_d   = head.dc_n;
            end
         end

         LOAD: begin
            do_pop  = 1'b1;
            shreg_d = head.data;
            sclk_d  = 1'b0;
            hcnt_d  = '0;
            bit_d   = '0;
            state_d = SHIFT;
         end

         SHIFT: begin
            if (hcnt_q != HALF_LAST) begin
               hcnt_d = hcnt_q + 1'b1;
            end else begin
               hcnt_d = '0;
               if (!oled_spi_clk) begin
                  sclk_d = 1'b1;
               end else if (bit_q == LAST_BIT) begin
                  done_d  = 1'b1;
                  state_d = GAP;
               end else begin
                  sclk_d  = 1'b0;
                  shreg_d = {shreg_q[SPI_BITS-2:0], 1'b0};
                  bit_d   = bit_q + 1'b1;
               end
            end
         end

         GAP: begin
            if (hcnt_q != HALF_LAST) begin
               hcnt_d = hcnt_q + 1'b1;
            end else begin
               hcnt_d = '0;
               if (!fifo_empty) begin
                  state_d = LOAD;
                  dcn_d   = head.dc_n;
               end else begin
                  state_d = IDLE;
                  shreg_d = '0;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hcnt_q       <= '0;
         bit_q        <= '0;
         shreg_q      <= '0;
         oled_spi_clk <= 1'b1;
         oled_dc_n    <= OLED_CMD;
         byte_done    <= 1'b0;
         busy         <= 1'b0;
         tx.tx_ready  <= 1'b0;
      end else begin
         hcnt_q       <= hcnt_d;
         bit_q        <= bit_d;
         shreg_q      <= shreg_d;
         oled_spi_clk <= sclk_d;
         oled_dc_n    <= dcn_d;
         byte_done    <= done_d;
         busy         <= busy_d;
         tx.tx_ready  <= ready_d;
      end
   end

   // D/C# may only move while SCLK is high, between bytes.
   dc_stable_while_low: assert property (
      @(posedge clock) disable iff (reset) !oled_spi_clk |-> $stable(oled_dc_n));

   load_has_entry: assert property (
      @(posedge clock) disable iff (reset) (state_q == LOAD) |-> !fifo_empty);

   done_is_pulse: assert property (
      @(posedge clock) disable iff (reset) byte_done |=> !byte_done);

endmodule

// File: tb/tb_oled_spi_tx.sv
// Self-checking bench for oled_spi_tx: directed scenarios plus random bytes,
// scored against a wire-level model of what the panel should receive.
module tb_oled_spi_tx;

   typedef struct packed {
      logic       dc;
      logic [7:0] data;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   oled_spi_tx_if a_if ();
   oled_spi_tx_if b_if ();

   logic a_busy, a_done, a_sclk, a_mosi, a_dc;
   logic b_busy, b_done, b_sclk, b_mosi, b_dc;

   logic [7:0] drv_data = 8'h00;
   logic       drv_dc = 1'b0;
   logic       drv_valid = 1'b0;
   logic       sel = 1'b0;
   logic       mon_en = 1'b0;

   assign a_if.tx_data  = drv_data;
   assign a_if.tx_dc_n  = drv_dc;
   assign a_if.tx_valid = drv_valid && !sel;
   assign b_if.tx_data  = drv_data;
   assign b_if.tx_dc_n  = drv_dc;
   assign b_if.tx_valid = drv_valid && sel;

   oled_spi_tx #(.CLK_DIV(5), .FIFO_DEPTH(4)) dut_a (
      .clock        (clock),
      .reset        (reset),
      .tx           (a_if),
      .busy         (a_busy),
      .byte_done    (a_done),
      .oled_spi_clk (a_sclk),
      .oled_spi_data(a_mosi),
      .oled_dc_n    (a_dc)
   );

   oled_spi_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) dut_b (
      .clock        (clock),
      .reset        (reset),
      .tx           (b_if),
      .busy         (b_busy),
      .byte_done    (b_done),
      .oled_spi_clk (b_sclk),
      .oled_spi_data(b_mosi),
      .oled_dc_n    (b_dc)
   );

   logic m_sclk, m_mosi, m_dc, m_done, m_busy, m_ready;
   int   div;
   assign m_sclk  = sel ? b_sclk : a_sclk;
   assign m_mosi  = sel ? b_mosi : a_mosi;
   assign m_dc    = sel ? b_dc : a_dc;
   assign m_done  = sel ? b_done : a_done;
   assign m_busy  = sel ? b_busy : a_busy;
   assign m_ready = sel ? b_if.tx_ready : a_if.tx_ready;
   assign div     = sel ? 1 : 5;

   int errors = 0;
   int checks = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                  tag, actual, actual, expected, expected);
      end
   endtask

   exp_t exp_q[$];
   int   accepted = 0;
   int   first_stall = -1;

   // Reference model: every accepted byte must appear as 8 rising-edge samples
   // 2*div apart, with its own D/C#, followed by byte_done div cycles later.
   logic       prev_sclk = 1'b1, prev_dc = 1'b0, prev_busy = 1'b0;
   int         bit_m = 0;
   logic [7:0] shift_m = 8'h00;
   logic [7:0] last_byte_rx = 8'h00;
   int         last_rise = 0, byte_last_rise = 0, last_gap = 0;
   int         pending_done = -1;
   int         rise_total = 0, done_total = 0, bytes_total = 0;
   int         done_cyc = 0, busy_fall_cyc = 0;

   always @(negedge clock) begin
      if (!mon_en) begin
         bit_m        = 0;
         pending_done = -1;
      end else begin
         if (m_dc !== prev_dc) checkOutput("dc_change_sclk_high", m_sclk, 1);
         if (prev_sclk && !m_sclk && bit_m == 0) last_gap = cyc - byte_last_rise;
         if (!prev_sclk && m_sclk) begin
            rise_total++;
            if (bit_m > 0) checkOutput("sclk_period", cyc - last_rise, 2 * div);
            checkOutput("rise_has_pending_byte", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) checkOutput("dc_n_during_byte", m_dc, exp_q[0].dc);
            shift_m   = {shift_m[6:0], m_mosi};
            bit_m++;
            last_rise = cyc;
            if (bit_m == 8) begin
               if (exp_q.size() != 0) begin
                  checkOutput("byte_value", shift_m, exp_q[0].data);
                  void'(exp_q.pop_front());
               end
               last_byte_rx   = shift_m;
               bytes_total++;
               byte_last_rise = cyc;
               pending_done   = cyc + div;
               bit_m          = 0;
            end
         end
         if (m_done) begin
            done_total++;
            done_cyc = cyc;
            checkOutput("byte_done_cycle", cyc, pending_done);
            pending_done = -1;
         end
         if (prev_busy && !m_busy) busy_fall_cyc = cyc;
      end
      prev_sclk = m_sclk;
      prev_dc   = m_dc;
      prev_busy = m_busy;
   end

   // Offers one byte and holds it until accepted; e0 is the handshake edge.
   task automatic applyStimulus(input logic [7:0] data, input logic dc, output int e0);
      int waited = 0;
      @(negedge clock);
      drv_data  = data;
      drv_dc    = dc;
      drv_valid = 1'b1;
      while (!m_ready && waited < 2000) begin
         if (first_stall < 0) first_stall = accepted;
         waited++;
         @(negedge clock);
      end
      if (!m_ready) begin
         checkOutput("accept_timeout", m_ready, 1);
         drv_valid = 1'b0;
         e0 = -1;
      end else begin
         @(posedge clock);
         #1;
         e0 = cyc;
         exp_q.push_back('{dc: dc, data: data});
         accepted++;
         drv_valid = 1'b0;
      end
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while ((m_busy || exp_q.size() != 0) && n < budget);
      checkOutput("idle_reached", m_busy, 0);
      @(negedge clock);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int e0, r0, d0, n;

      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_sclk", a_sclk, 1);
      checkOutput("reset_mosi", a_mosi, 0);
      checkOutput("reset_dc_n", a_dc, 0);
      checkOutput("reset_ready", a_if.tx_ready, 0);
      checkOutput("reset_busy", a_busy, 0);
      checkOutput("reset_done", a_done, 0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("ready_after_reset", a_if.tx_ready, 1);
      checkOutput("busy_after_reset", a_busy, 0);
      @(negedge clock);
      mon_en = 1'b1;

      $display("[TB] single byte 0xA5");
      r0 = rise_total;
      d0 = done_total;
      applyStimulus(8'hA5, 1'b0, e0);
      waitIdle(300);
      checkOutput("a5_rises", rise_total - r0, 8);
      checkOutput("a5_done_count", done_total - d0, 1);
      checkOutput("a5_done_cycle", done_cyc - e0, 82);
      checkOutput("a5_busy_fall", busy_fall_cyc - e0, 87);
      checkOutput("a5_byte", last_byte_rx, 8'hA5);

      $display("[TB] back-to-back 0xAE cmd, 0xFF data");
      d0 = done_total;
      applyStimulus(8'hAE, 1'b0, e0);
      applyStimulus(8'hFF, 1'b1, e0);
      waitIdle(400);
      checkOutput("b2b_gap", last_gap, 11);
      checkOutput("b2b_done_count", done_total - d0, 2);
      checkOutput("b2b_last_byte", last_byte_rx, 8'hFF);

      $display("[TB] backpressure 0x01..0x06");
      accepted    = 0;
      first_stall = -1;
      for (int i = 1; i <= 6; i++) applyStimulus(8'(i), 1'b1, e0);
      waitIdle(1500);
      checkOutput("bp_accepted", accepted, 6);
      checkOutput("bp_stall_point", first_stall, 5);
      checkOutput("bp_last_byte", last_byte_rx, 8'h06);

      $display("[TB] reset mid-byte on 0x3C");
      applyStimulus(8'h3C, 1'b1, e0);
      n = 0;
      while (bit_m < 3 && n < 200) begin
         @(negedge clock);
         n++;
      end
      checkOutput("mid_reached_bit", bit_m, 3);
      @(negedge clock);
      mon_en = 1'b0;
      reset  = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("mid_reset_sclk", a_sclk, 1);
      checkOutput("mid_reset_mosi", a_mosi, 0);
      checkOutput("mid_reset_busy", a_busy, 0);
      checkOutput("mid_reset_dc_n", a_dc, 0);
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      @(negedge clock);
      mon_en = 1'b1;
      r0     = rise_total;
      repeat (40) @(negedge clock);
      checkOutput("mid_no_rises", rise_total - r0, 0);
      checkOutput("mid_busy_idle", a_busy, 0);
      applyStimulus(8'h55, 1'b1, e0);
      waitIdle(300);
      checkOutput("mid_clean_byte", last_byte_rx, 8'h55);

      $display("[TB] CLK_DIV=1 byte 0x81");
      mon_en = 1'b0;
      @(negedge clock);
      sel = 1'b1;
      repeat (2) @(negedge clock);
      mon_en = 1'b1;
      r0 = rise_total;
      d0 = done_total;
      applyStimulus(8'h81, 1'b1, e0);
      waitIdle(100);
      checkOutput("div1_rises", rise_total - r0, 8);
      checkOutput("div1_done_count", done_total - d0, 1);
      checkOutput("div1_done_cycle", done_cyc - e0, 18);
      checkOutput("div1_busy_fall", busy_fall_cyc - e0, 19);
      checkOutput("div1_byte", last_byte_rx, 8'h81);

      $display("[TB] random bytes, CLK_DIV=1");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8'($urandom), 1'($urandom), e0);
         repeat ($urandom_range(0, 6)) @(negedge clock);
      end
      waitIdle(2000);

      mon_en = 1'b0;
      @(negedge clock);
      sel = 1'b0;
      repeat (2) @(negedge clock);
      mon_en = 1'b1;

      $display("[TB] random bytes, CLK_DIV=5");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(8'($urandom), 1'($urandom), e0);
         repeat ($urandom_range(0, 30)) @(negedge clock);
      end
      waitIdle(4000);
      checkOutput("rand_done_matches_bytes", done_total, bytes_total);
      checkOutput("rand_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
